// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse train sequencer: FSM state encoding,
// default widths and the slice helper used to unpack the flat per-channel buses.
package pulse_seq_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned DEF_NCH = 4;
  localparam int unsigned DEF_TW  = 32;
  localparam int unsigned DEF_CW  = 16;

  // LSB of channel idx inside a flat bus of w-bit fields
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

// File: rtl/pulse_window.sv
// One channel's pulse gate: high while delay <= t < delay+width within the period,
// evaluated on the next-state timebase so the registered output lines up with it.
module pulse_window #(
  parameter int unsigned TW = pulse_seq_pkg::DEF_TW
) (
  input  logic          clk_Seq,
  input  logic          rst,
  input  logic [TW-1:0] delay_i,
  input  logic [TW-1:0] width_i,
  input  logic [TW-1:0] period_i,
  input  logic [TW-1:0] t_next_i,
  input  logic          run_next_i,
  output logic          ch_o
);

  logic [TW:0] end_w;
  logic        hit_c;

  // End of window is one bit wider so delay+width can never wrap
  assign end_w = {1'b0, delay_i} + {1'b0, width_i};
  assign hit_c = run_next_i
               && (t_next_i >= delay_i)
               && ({1'b0, t_next_i} < end_w)
               && (t_next_i < period_i);

  always_ff @(posedge clk_Seq) begin
    if (rst) begin
      ch_o <= 1'b0;
    end else begin
      ch_o <= hit_c;
    end
  end

endmodule

// File: rtl/pulse_train_sequencer.sv
// Multi-channel pulse train scheduler: latches the config on trigger, runs N
// repetitions of period P and gates each channel by its own delay/width window.
module pulse_train_sequencer #(
  parameter int unsigned NCH = pulse_seq_pkg::DEF_NCH,
  parameter int unsigned TW  = pulse_seq_pkg::DEF_TW,
  parameter int unsigned CW  = pulse_seq_pkg::DEF_CW
) (
  input  logic              clk_Seq,
  input  logic              rst,
  input  logic              trig,
  input  logic              abort,
  input  logic [TW-1:0]     period,
  input  logic [CW-1:0]     n_pulses,
  input  logic [NCH*TW-1:0] delay_bus,
  input  logic [NCH*TW-1:0] width_bus,
  output logic [NCH-1:0]    ch_out,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic [CW-1:0]     rep_idx
);

  import pulse_seq_pkg::*;

  state_e            state_q, state_d;
  logic [TW-1:0]     t_q, t_d;
  logic [CW-1:0]     rep_q, rep_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic [TW-1:0]     per_q, per_d;
  logic [CW-1:0]     num_q, num_d;
  logic [NCH*TW-1:0] dly_q, dly_d;
  logic [NCH*TW-1:0] wid_q, wid_d;

  always_ff @(posedge clk_Seq) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      rep_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      per_q     <= '0;
      num_q     <= '0;
      dly_q     <= '0;
      wid_q     <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      rep_q     <= rep_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
      per_q     <= per_d;
      num_q     <= num_d;
      dly_q     <= dly_d;
      wid_q     <= wid_d;
    end
  end

  // busy_q doubles as "timebase live": the first RUN cycle only arms t=0
  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    rep_d     = rep_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cfg_err_d = 1'b0;
    per_d     = per_q;
    num_d     = num_q;
    dly_d     = dly_q;
    wid_d     = wid_q;
    case (state_q)
      ST_IDLE: begin
        t_d    = '0;
        rep_d  = '0;
        busy_d = 1'b0;
        if (trig) begin
          if ((period == '0) || (n_pulses == '0)) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            per_d   = period;
            num_d   = n_pulses;
            dly_d   = delay_bus;
            wid_d   = width_bus;
          end
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          t_d     = '0;
          rep_d   = '0;
          busy_d  = 1'b0;
        end else if (!busy_q) begin
          busy_d = 1'b1;
          t_d    = '0;
          rep_d  = '0;
        end else if (t_q == per_q - TW'(1)) begin
          t_d = '0;
          if (rep_q == num_q - CW'(1)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            rep_d   = '0;
            done_d  = 1'b1;
          end else begin
            rep_d = rep_q + CW'(1);
          end
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam int unsigned LSB = field_lsb(i, TW);
    pulse_window #(.TW(TW)) u_win (
      .clk_Seq    (clk_Seq),
      .rst        (rst),
      .delay_i    (dly_q[LSB +: TW]),
      .width_i    (wid_q[LSB +: TW]),
      .period_i   (per_q),
      .t_next_i   (t_d),
      .run_next_i (busy_d),
      .ch_o       (ch_out[i])
    );
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign cfg_err = cfg_err_q;
  assign rep_idx = rep_q;

endmodule

// File: tb/tb_pulse_train_sequencer.sv
// Directed bench for pulse_train_sequencer (2 channels): checks trains, rejects,
// abort, back-to-back retrigger, config latching, corner widths and reset.
module tb_pulse_train_sequencer;

  localparam int unsigned NCH = 2;
  localparam int unsigned TW  = 32;
  localparam int unsigned CW  = 16;

  logic              clk_Seq;
  logic              rst;
  logic              trig;
  logic              abort;
  logic [TW-1:0]     period;
  logic [CW-1:0]     n_pulses;
  logic [NCH*TW-1:0] delay_bus;
  logic [NCH*TW-1:0] width_bus;
  logic [NCH-1:0]    ch_out;
  logic              busy;
  logic              done;
  logic              cfg_err;
  logic [CW-1:0]     rep_idx;

  int n_cmp = 0;
  int n_mis = 0;
  int p_cfg, n_cfg;
  int d_cfg [2];
  int w_cfg [2];
  logic [1:0] hist [0:40];

  pulse_train_sequencer #(.NCH(NCH), .TW(TW), .CW(CW)) dut (
    .clk_Seq   (clk_Seq),
    .rst       (rst),
    .trig      (trig),
    .abort     (abort),
    .period    (period),
    .n_pulses  (n_pulses),
    .delay_bus (delay_bus),
    .width_bus (width_bus),
    .ch_out    (ch_out),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .rep_idx   (rep_idx)
  );

  initial clk_Seq = 1'b0;
  always #5 clk_Seq = ~clk_Seq;

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk_Seq);
    #1;
  endtask

  function automatic logic [31:0] obs_vec();
    return {11'b0, cfg_err, done, busy, rep_idx, ch_out};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int p, input int n, input int d0, input int w0,
                         input int d1, input int w1);
    p_cfg = p; n_cfg = n;
    d_cfg[0] = d0; w_cfg[0] = w0; d_cfg[1] = d1; w_cfg[1] = w1;
    period    = TW'(p);
    n_pulses  = CW'(n);
    delay_bus = {TW'(d1), TW'(d0)};
    width_bus = {TW'(w1), TW'(w0)};
  endtask

  // Expected {cfg_err, done, busy, rep_idx, ch_out} in cycle c of the train
  function automatic logic [31:0] model(input int c);
    logic [31:0] v;
    int np, t;
    v  = '0;
    np = p_cfg * n_cfg;
    if (c >= 1 && c <= np) begin
      t = (c - 1) % p_cfg;
      v[18] = 1'b1;
      v[17:2] = 16'((c - 1) / p_cfg);
      for (int i = 0; i < 2; i++)
        if (t >= d_cfg[i] && t < d_cfg[i] + w_cfg[i]) v[i] = 1'b1;
    end
    if (c == np + 1) v[19] = 1'b1;
    return v;
  endfunction

  task automatic run_train(input string tag, input int ncyc, input bit keep_trig,
                           input bit abort_at_e0, input int scramble_at, input int abort_at);
    logic [31:0] o;
    trig  = 1'b1;
    abort = abort_at_e0;
    step();
    trig  = keep_trig;
    abort = 1'b0;
    chk($sformatf("%s c=0", tag), obs_vec(), model(0));
    for (int c = 1; c <= ncyc; c++) begin
      step();
      o = obs_vec();
      hist[c] = o[1:0];
      chk($sformatf("%s c=%0d", tag, c), o, model(c));
      if (c == scramble_at) begin
        period    = TW'(3);
        n_pulses  = CW'(1);
        delay_bus = {TW'(0), TW'(7)};
        width_bus = {TW'(1), TW'(1)};
      end
      if (c == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk($sformatf("%s abort", tag), obs_vec(), 32'h0);
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; trig = 1'b0; abort = 1'b0;
    set_cfg(10, 3, 0, 3, 5, 10);
    step();
    step();
    chk("reset", obs_vec(), 32'h0);
    rst = 1'b0;
    step();
    chk("idle", obs_vec(), 32'h0);

    // Basic train; inputs scrambled at c=15 must not disturb it
    run_train("basic", 32, 1'b0, 1'b0, 15, 0);
    chk("basic ch c=3",  {30'b0, hist[3]},  32'h1);
    chk("basic ch c=4",  {30'b0, hist[4]},  32'h0);
    chk("basic ch c=6",  {30'b0, hist[6]},  32'h2);
    chk("basic ch c=11", {30'b0, hist[11]}, 32'h1);
    chk("basic ch c=30", {30'b0, hist[30]}, 32'h2);
    chk("basic ch c=31", {30'b0, hist[31]}, 32'h0);

    // Config reject: P==0, then N==0
    set_cfg(0, 5, 0, 3, 5, 10);
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("rej P0", obs_vec(), 32'h0010_0000);
    step();
    chk("rej P0 next", obs_vec(), 32'h0);
    set_cfg(10, 0, 0, 3, 5, 10);
    trig = 1'b1;
    step();
    trig = 1'b0;
    chk("rej N0", obs_vec(), 32'h0010_0000);
    step();
    chk("rej N0 next", obs_vec(), 32'h0);

    // Abort at c=14, then abort alone in IDLE, then trig+abort in IDLE replays
    set_cfg(10, 3, 0, 3, 5, 10);
    run_train("abort", 20, 1'b0, 1'b0, 0, 14);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("post-abort %0d", k), obs_vec(), 32'h0);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort idle", obs_vec(), 32'h0);
    run_train("replay", 31, 1'b0, 1'b1, 0, 0);

    // Back-to-back: trig held, second E0 is the done-cycle edge
    step();
    run_train("b2b1", 31, 1'b1, 1'b0, 0, 0);
    run_train("b2b2", 31, 1'b0, 1'b0, 0, 0);

    // Corner widths
    step();
    set_cfg(10, 3, 0, 0, 12, 4);
    run_train("dead", 31, 1'b0, 1'b0, 0, 0);
    step();
    set_cfg(10, 3, 0, 10, 9, 5);
    run_train("full", 31, 1'b0, 1'b0, 0, 0);
    chk("full ch c=10", {30'b0, hist[10]}, 32'h3);
    chk("full ch c=11", {30'b0, hist[11]}, 32'h1);
    step();
    set_cfg(1, 1, 0, 1, 0, 0);
    run_train("p1n1", 2, 1'b0, 1'b0, 0, 0);

    // Reset mid-train with a simultaneous trig
    step();
    set_cfg(10, 3, 0, 3, 5, 10);
    trig = 1'b1;
    step();
    trig = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    chk("pre-rst c=7", obs_vec(), 32'h0004_0002);
    rst = 1'b1;
    trig = 1'b1;
    step();
    chk("rst mid", obs_vec(), 32'h0);
    rst = 1'b0;
    trig = 1'b0;
    step();
    chk("rst trig ignored", obs_vec(), 32'h0);
    step();
    chk("rst idle", obs_vec(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
